// File: rtl/delay_mem_arbiter_pkg.sv
// Shared definitions for the delay-line RAM arbiter.
// The allocation FSM encodings, the read latency and a slice helper for
// the flattened per-requester buses all live here.
// The optional stall counters are enabled with DELAY_MEM_ARB_STATS_EN.

`ifndef DELAY_MEM_ARBITER_PKG_SV
`define DELAY_MEM_ARBITER_PKG_SV

// Extract slice idx of width w from a flattened bus.
`define DLY_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package delay_mem_arbiter_pkg;

  // Allocation FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FAIL   = 2'd3
  } alloc_state_t;

  // Cycles from handshake to rsp_valid.
  localparam int RD_LATENCY = 3;

endpackage

`endif

// File: rtl/delay_mem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps modulo N. The first valid requester
// wins, so there is never more than one grant.

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int idx;

  // Priority scan from ptr upward; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_any && valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/delay_mem_arbiter.sv
// Shares one single-port delay RAM among N_REQ pipeline blocks.
// Each block addresses its own relocatable region. Regions are carved out
// sequentially by the allocation FSM and released all at once by alloc_clear.
// Pipeline: grant (T), RAM access (T+1), RAM data (T+2), response (T+3).
// Optional: DELAY_MEM_ARB_STATS_EN adds per-requester stall counters.
//
// Handshake: a requester raises req_valid and holds valid, write, addr and
// wdata steady. The transfer happens on the edge where req_valid and
// req_ready are both high. req_ready is one-hot, combinational and is held
// low during reset.

module delay_mem_arbiter
  import delay_mem_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          alloc_valid,
  input  logic [$clog2(N_REQ)-1:0]      alloc_id,
  input  logic [ADDR_WIDTH-1:0]         alloc_size,
  input  logic                          alloc_clear,
  output logic                          alloc_busy,
  output logic                          alloc_done,
  output logic                          alloc_fail,
`ifdef DELAY_MEM_ARB_STATS_EN
  output logic [N_REQ*16-1:0]           stall_count,
`endif
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [ADDR_WIDTH:0] SPACE = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Arbitration
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_raw;
  logic             grant_any_raw;
  logic             grant_any;

  // Region table
  logic [ADDR_WIDTH-1:0] base_q [N_REQ];
  logic [ADDR_WIDTH-1:0] size_q [N_REQ];
  logic [N_REQ-1:0]      allocated_q;
  logic [ADDR_WIDTH-1:0] next_free;

  // Allocation FSM
  alloc_state_t          alloc_state;
  logic [IDX_W-1:0]      pend_id;
  logic [ADDR_WIDTH-1:0] pend_size;
  logic [ADDR_WIDTH:0]   alloc_end;
  logic                  alloc_over;

  // Read pipeline
  logic             s1_read;
  logic [IDX_W-1:0] s1_id;
  logic             s2_read;
  logic             s2_en;
  logic [IDX_W-1:0] s2_id;
  logic [N_REQ-1:0] s2_onehot;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant_raw),
    .grant_idx (grant_idx),
    .grant_any (grant_any_raw)
  );

  assign req_ready = reset ? '0 : grant_raw;
  assign grant_any = grant_any_raw & ~reset;

  // Advance the round-robin pointer past the winner; hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Access stage: relocate the granted request into its region.
  // Unallocated requesters are granted, but they never touch the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_read   <= 1'b0;
      s1_id     <= '0;
    end else begin
      mem_en  <= grant_any & allocated_q[grant_idx];
      mem_we  <= grant_any & allocated_q[grant_idx] & req_write[grant_idx];
      s1_read <= grant_any & ~req_write[grant_idx];
      s1_id   <= grant_idx;
      if (grant_any) begin
        mem_addr  <= base_q[grant_idx] + `DLY_SLICE(req_addr, grant_idx, ADDR_WIDTH);
        mem_wdata <= `DLY_SLICE(req_wdata, grant_idx, DATA_WIDTH);
      end
    end
  end

  // RAM data stage: track which read the RAM is answering this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_read <= 1'b0;
      s2_en   <= 1'b0;
      s2_id   <= '0;
    end else begin
      s2_read <= s1_read;
      s2_en   <= mem_en;
      s2_id   <= s1_id;
    end
  end

  // Decode the responding requester into a one-hot strobe.
  always_comb begin
    s2_onehot        = '0;
    s2_onehot[s2_id] = 1'b1;
  end

  // Response stage: register RAM data, or zero for an unallocated read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s2_read ? s2_onehot : '0;
      if (s2_read) begin
        rsp_data <= s2_en ? mem_rdata : '0;
      end
    end
  end

  // The region check uses one extra bit so that a region ending exactly at the top of the RAM fits.
  always_comb begin
    alloc_end  = {1'b0, next_free} + {1'b0, pend_size};
    alloc_over = (alloc_end > SPACE) || (pend_size == '0);
  end

  // Allocation FSM. alloc_clear overrides every state and never pulses done or fail.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_state <= ST_IDLE;
      alloc_busy  <= 1'b0;
      alloc_done  <= 1'b0;
      alloc_fail  <= 1'b0;
      pend_id     <= '0;
      pend_size   <= '0;
      next_free   <= '0;
      allocated_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      alloc_done <= 1'b0;
      alloc_fail <= 1'b0;
      if (alloc_clear) begin
        alloc_state <= ST_IDLE;
        alloc_busy  <= 1'b0;
        next_free   <= '0;
        allocated_q <= '0;
      end else begin
        case (alloc_state)
          ST_IDLE: begin
            if (alloc_valid) begin
              pend_id     <= alloc_id;
              pend_size   <= alloc_size;
              alloc_busy  <= 1'b1;
              alloc_state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            alloc_state <= alloc_over ? ST_FAIL : ST_COMMIT;
          end
          ST_COMMIT: begin
            base_q[pend_id]      <= next_free;
            size_q[pend_id]      <= pend_size;
            allocated_q[pend_id] <= 1'b1;
            next_free            <= next_free + pend_size;
            alloc_done           <= 1'b1;
            alloc_busy           <= 1'b0;
            alloc_state          <= ST_IDLE;
          end
          ST_FAIL: begin
            alloc_fail  <= 1'b1;
            alloc_busy  <= 1'b0;
            alloc_state <= ST_IDLE;
          end
          default: begin
            alloc_busy  <= 1'b0;
            alloc_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Every live region lies entirely inside the RAM.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_region_fits
    region_fits: assert property (@(posedge clk) disable iff (reset)
      allocated_q[gi] |-> (({1'b0, base_q[gi]} + {1'b0, size_q[gi]}) <= SPACE));
  end

`ifdef DELAY_MEM_ARB_STATS_EN
  logic [15:0] stall_q [N_REQ];

  // Count the cycles each requester waits, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset || alloc_clear) begin
      for (int i = 0; i < N_REQ; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && stall_q[i] != 16'hFFFF) begin
          stall_q[i] <= stall_q[i] + 16'd1;
        end
      end
    end
  end

  for (genvar gs = 0; gs < N_REQ; gs++) begin : g_stall_out
    assign stall_count[gs*16 +: 16] = stall_q[gs];
  end
`endif

endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Directed bench for delay_mem_arbiter. Single-access vectors come from a
// table. The round-robin, clear, capacity and reset sequences are written
// out by hand. A small behavioural RAM with one cycle of read latency
// answers mem_* accesses.

module tb_delay_mem_arbiter;
  import delay_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [15:0] rsp_data;
  logic        alloc_valid, alloc_clear, alloc_busy, alloc_done, alloc_fail;
  logic [1:0]  alloc_id;
  logic [15:0] alloc_size;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DELAY_MEM_ARB_STATS_EN
  logic [63:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] ram [0:65535];

  typedef struct {
    int          id;
    logic        wr;
    logic [15:0] off;
    logic [15:0] wd;
    logic        exp_en;
    logic [15:0] exp_addr;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  delay_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .alloc_valid (alloc_valid),
    .alloc_id    (alloc_id),
    .alloc_size  (alloc_size),
    .alloc_clear (alloc_clear),
    .alloc_busy  (alloc_busy),
    .alloc_done  (alloc_done),
    .alloc_fail  (alloc_fail),
`ifdef DELAY_MEM_ARB_STATS_EN
    .stall_count (stall_count),
`endif
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural single-port RAM, read data one cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One access from requester id. The task captures the access stage at T+1 and the response at T+3.
  task automatic do_access(input int id, input logic wr, input logic [15:0] off,
                           input logic [15:0] wd, output logic ok,
                           output logic g_en, output logic g_we,
                           output logic [15:0] g_addr, output logic [15:0] g_wdata,
                           output logic [3:0] g_rv, output logic [15:0] g_rd);
    int n;
    @(posedge clk); #1;
    req_write[id]         = wr;
    req_addr[id*16 +: 16]  = off;
    req_wdata[id*16 +: 16] = wd;
    req_valid[id]         = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready[id];
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    g_en = mem_en; g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
    @(negedge clk);
    @(negedge clk);
    g_rv = rsp_valid; g_rd = rsp_data;
  endtask

  task automatic do_alloc(input logic [1:0] id, input logic [15:0] size,
                          input logic exp_ok, input string name);
    int n;
    @(posedge clk); #1;
    alloc_id = id; alloc_size = size; alloc_valid = 1'b1;
    @(posedge clk); #1;
    alloc_valid = 1'b0;
    @(negedge clk);
    check({name, " busy"}, alloc_busy, 1);
    n = 0;
    while (!(alloc_done || alloc_fail) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, " done"}, alloc_done, exp_ok);
    check({name, " fail"}, alloc_fail, !exp_ok);
  endtask

  // Single access whose T+1 address and enable are checked.
  task automatic addr_check(input int id, input logic [15:0] off, input logic exp_en,
                            input logic [15:0] exp_addr, input string name);
    logic ok, e, w;
    logic [15:0] a, d, rd;
    logic [3:0] rv;
    do_access(id, 1'b0, off, 16'h0, ok, e, w, a, d, rv, rd);
    check({name, " handshake"}, ok, 1);
    check({name, " mem_en"}, e, exp_en);
    if (exp_en) check({name, " mem_addr"}, a, exp_addr);
  endtask

  initial begin
    logic ok, g_en, g_we;
    logic [15:0] g_addr, g_wdata, g_rd;
    logic [3:0]  g_rv;
    logic [3:0]  rr_exp [5];
    logic [15:0] rr_rd [5];
    logic [15:0] rr_off [4];
    int pulses, n, rvseen;

    for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
    ram[16'h0180] = 16'hBEEF;
    mem_rdata = 16'h0;

    vecs[0] = '{1, 1'b1, 16'h0005, 16'h1234, 1'b1, 16'h0105, 16'h0000};
    vecs[1] = '{0, 1'b1, 16'h0010, 16'hAAAA, 1'b1, 16'h0010, 16'h0000};
    vecs[2] = '{2, 1'b1, 16'hFFFF, 16'h5555, 1'b1, 16'h017F, 16'h0000};
    vecs[3] = '{2, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0180, 16'hBEEF};
    vecs[4] = '{3, 1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h0105, 16'h1234};
    vecs[6] = '{0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0010, 16'hAAAA};
    vecs[7] = '{3, 1'b1, 16'h0000, 16'h7777, 1'b0, 16'h0000, 16'h0000};

    // Reset, with a requester already valid
    reset = 1'b1;
    req_valid = 4'b0001; req_write = '0; req_addr = '0; req_wdata = '0;
    alloc_valid = 1'b0; alloc_clear = 1'b0; alloc_id = '0; alloc_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset mem_en/we", {mem_en, mem_we}, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset alloc flags", {alloc_busy, alloc_done, alloc_fail}, 0);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b0;

    // Regions: id0 at 0x000, id1 at 0x100, id2 at 0x180
    do_alloc(2'd0, 16'h0100, 1'b1, "alloc id0");
    do_alloc(2'd1, 16'h0080, 1'b1, "alloc id1");
    do_alloc(2'd2, 16'h0040, 1'b1, "alloc id2");

    // Table-driven single accesses
    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].id, vecs[i].wr, vecs[i].off, vecs[i].wd, ok,
                g_en, g_we, g_addr, g_wdata, g_rv, g_rd);
      check($sformatf("vec%0d handshake", i), ok, 1);
      check($sformatf("vec%0d mem_en", i), g_en, vecs[i].exp_en);
      check($sformatf("vec%0d mem_we", i), g_we, vecs[i].exp_en & vecs[i].wr);
      if (vecs[i].exp_en) check($sformatf("vec%0d mem_addr", i), g_addr, vecs[i].exp_addr);
      if (vecs[i].exp_en && vecs[i].wr) check($sformatf("vec%0d mem_wdata", i), g_wdata, vecs[i].wd);
      check($sformatf("vec%0d rsp_valid", i), g_rv, vecs[i].wr ? 4'b0000 : 4'(1 << vecs[i].id));
      if (!vecs[i].wr) check($sformatf("vec%0d rsp_data", i), g_rd, vecs[i].exp_rd);
    end

    // All four valid from pointer 0: grants 0,1,2,3,0 and responses in grant order
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_rd  = '{16'hAAAA, 16'h1234, 16'hBEEF, 16'h0000, 16'hAAAA};
    rr_off = '{16'h0010, 16'h0005, 16'h0000, 16'h0007};
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      req_write[r] = 1'b0;
      req_addr[r*16 +: 16] = rr_off[r];
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 5) check($sformatf("rr grant %0d", k), req_ready, rr_exp[k]);
      if (k >= RD_LATENCY) begin
        check($sformatf("rr rsp_valid %0d", k), rsp_valid, rr_exp[k-RD_LATENCY]);
        check($sformatf("rr rsp_data %0d", k), rsp_data, rr_rd[k-RD_LATENCY]);
      end else begin
        check($sformatf("rr early rsp_valid %0d", k), rsp_valid, 0);
      end
      if (k == 4) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
    end

    // Clear together with an allocation request, while a read is in flight
    @(posedge clk); #1;
    req_write[2] = 1'b0; req_addr[32 +: 16] = 16'h0000; req_valid[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clr handshake", req_ready[2], 1);
    @(posedge clk); #1;
    req_valid = '0;
    alloc_valid = 1'b1; alloc_clear = 1'b1; alloc_id = 2'd0; alloc_size = 16'h0010;
    @(negedge clk);
    pulses = int'(alloc_done) + int'(alloc_fail);
    check("clr inflight mem_en", mem_en, 1);
    check("clr inflight mem_addr", mem_addr, 16'h0180);
    @(posedge clk); #1;
    alloc_valid = 1'b0; alloc_clear = 1'b0;
    @(negedge clk);
    pulses += int'(alloc_done) + int'(alloc_fail);
    check("clr busy", alloc_busy, 0);
    @(negedge clk);
    pulses += int'(alloc_done) + int'(alloc_fail);
    check("clr inflight rsp_valid", rsp_valid, 4'b0100);
    check("clr inflight rsp_data", rsp_data, 16'hBEEF);
    repeat (3) begin
      @(negedge clk);
      pulses += int'(alloc_done) + int'(alloc_fail);
    end
    check("clr no pulses", pulses, 0);

    // Flags are gone: id2 reads as unallocated
    do_access(2, 1'b0, 16'h0000, 16'h0, ok, g_en, g_we, g_addr, g_wdata, g_rv, g_rd);
    check("post-clr id2 mem_en", g_en, 0);
    check("post-clr id2 rsp_valid", g_rv, 4'b0100);
    check("post-clr id2 rsp_data", g_rd, 0);

    // next_free was zeroed, so the new region starts at 0
    do_alloc(2'd0, 16'h0010, 1'b1, "realloc id0");
    addr_check(0, 16'h0003, 1'b1, 16'h0003, "realloc id0 access");

    // Clear while the FSM sits in CHECK: the allocation is abandoned silently
    @(posedge clk); #1;
    alloc_id = 2'd1; alloc_size = 16'h0020; alloc_valid = 1'b1;
    @(posedge clk); #1;
    alloc_valid = 1'b0; alloc_clear = 1'b1;
    @(negedge clk);
    check("check-state busy", alloc_busy, 1);
    @(posedge clk); #1;
    alloc_clear = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(alloc_done) + int'(alloc_fail);
    end
    check("check-state clear pulses", pulses, 0);
    check("check-state clear busy", alloc_busy, 0);

    // Capacity: fill to 0xFF00, then one oversize, one zero-size and one exact fit
    do_alloc(2'd0, 16'h8000, 1'b1, "cap id0");
    do_alloc(2'd1, 16'h7F00, 1'b1, "cap id1");
    do_alloc(2'd2, 16'h0200, 1'b0, "cap id2 oversize");
    do_alloc(2'd2, 16'h0000, 1'b0, "cap id2 zero");
    do_alloc(2'd2, 16'h0100, 1'b1, "cap id2 exact");
    do_alloc(2'd3, 16'h0001, 1'b1, "cap id3 wrapped");
    addr_check(1, 16'h0000, 1'b1, 16'h8000, "cap id1 base");
    addr_check(2, 16'h0000, 1'b1, 16'hFF00, "cap id2 base");
    addr_check(3, 16'h0000, 1'b1, 16'h0000, "cap id3 base");

    // Reset while a read is in flight: its response is dropped
    @(posedge clk); #1;
    req_write[1] = 1'b0; req_addr[16 +: 16] = 16'h0000; req_valid[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst-mid handshake", req_ready[1], 1);
    @(posedge clk); #1;
    req_valid = '0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rvseen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid != 4'b0000) rvseen++;
    end
    check("rst-mid dropped rsp", rvseen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
